// File: rtl/encoder_4x2_sync.sv
// encoder_4x2_sync: registered 4-to-2 priority encoder with any/multi flags,
// a one-entry valid/ready output stage and a saturating transfer counter.
module encoder_4x2_sync #(
   parameter int CNT_W     = 8,
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       d,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [1:0]       y,
   output logic             any,
   output logic             multi,
   output logic [CNT_W-1:0] evt_cnt
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;
   logic [0:0] state;
   logic [1:0] enc_y;
   logic       enc_any, enc_multi, accept, xfer;
   always_comb begin
      enc_y = PRIO_HIGH ? (d[3] ? 2'd3 : d[2] ? 2'd2 : d[1] ? 2'd1 : 2'd0)
                        : (d[0] ? 2'd0 : d[1] ? 2'd1 : d[2] ? 2'd2 : d[3] ? 2'd3 : 2'd0);
      enc_y = en ? enc_y : 2'd0;
      enc_any = en & |d;
      enc_multi = en & ((d[0] & (d[1] | d[2] | d[3])) | (d[1] & (d[2] | d[3])) | (d[2] & d[3]));
   end
   assign out_valid = (state == FULL);
   assign in_ready  = (state == EMPTY) | out_ready;
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         y       <= 2'd0;
         any     <= 1'b0;
         multi   <= 1'b0;
         evt_cnt <= '0;
      end else begin
         state <= accept ? FULL : xfer ? EMPTY : state;
         if (accept) begin
            y     <= enc_y;
            any   <= enc_any;
            multi <= enc_multi;
         end
         if (xfer && evt_cnt != {CNT_W{1'b1}})
            evt_cnt <= evt_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_encoder_4x2_sync.sv
// tb_encoder_4x2_sync: directed tests on three encoder variants sharing one stimulus
// (default, low-priority-first, and a 2-bit counter for saturation).
module tb_encoder_4x2_sync;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] d = 4'd0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       hi_in_ready, hi_out_valid, hi_any, hi_multi;
   logic       lo_in_ready, lo_out_valid, lo_any, lo_multi;
   logic       st_in_ready, st_out_valid, st_any, st_multi;
   logic [1:0] hi_y, lo_y, st_y;
   logic [7:0] hi_cnt, lo_cnt;
   logic [1:0] st_cnt;
   int errors = 0;
   int checks = 0;

   encoder_4x2_sync u_hi (
      .clk(clk), .rst(rst), .en(en), .d(d), .in_valid(in_valid), .in_ready(hi_in_ready),
      .out_ready(out_ready), .out_valid(hi_out_valid), .y(hi_y), .any(hi_any),
      .multi(hi_multi), .evt_cnt(hi_cnt));
   encoder_4x2_sync #(.PRIO_HIGH(1'b0)) u_lo (
      .clk(clk), .rst(rst), .en(en), .d(d), .in_valid(in_valid), .in_ready(lo_in_ready),
      .out_ready(out_ready), .out_valid(lo_out_valid), .y(lo_y), .any(lo_any),
      .multi(lo_multi), .evt_cnt(lo_cnt));
   encoder_4x2_sync #(.CNT_W(2)) u_st (
      .clk(clk), .rst(rst), .en(en), .d(d), .in_valid(in_valid), .in_ready(st_in_ready),
      .out_ready(out_ready), .out_valid(st_out_valid), .y(st_y), .any(st_any),
      .multi(st_multi), .evt_cnt(st_cnt));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; en = 1'b0; d = 4'd0;
      repeat (2) step();
      checks++;
      if ({hi_out_valid, hi_y, hi_any, hi_multi, hi_in_ready} !== 6'b0_00_00_1) begin
         errors++; $display("FAIL reset_outputs: got %b want 000001", {hi_out_valid, hi_y, hi_any, hi_multi, hi_in_ready});
      end
      checks++;
      if (hi_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", hi_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      out_ready = 1'b1; en = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = 4'(1 << i);
         step();
         checks++;
         if ({hi_out_valid, hi_y, hi_any, hi_multi} !== {1'b1, 2'(i), 2'b10}) begin
            errors++; $display("FAIL sweep_%0d: got %b want %b", i, {hi_out_valid, hi_y, hi_any, hi_multi}, {1'b1, 2'(i), 2'b10});
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if ({hi_out_valid, hi_cnt} !== {1'b0, 8'd4}) begin
         errors++; $display("FAIL sweep_cnt: got valid=%b cnt=%0d want valid=0 cnt=4", hi_out_valid, hi_cnt);
      end
   endtask

   task automatic test_priority();
      in_valid = 1'b1; out_ready = 1'b1; en = 1'b1;
      d = 4'b1010; step();
      checks++;
      if ({hi_y, hi_any, hi_multi} !== 4'b11_1_1) begin errors++; $display("FAIL prio_hi_1010: got %b want 1111", {hi_y, hi_any, hi_multi}); end
      checks++;
      if ({lo_y, lo_any, lo_multi} !== 4'b01_1_1) begin errors++; $display("FAIL prio_lo_1010: got %b want 0111", {lo_y, lo_any, lo_multi}); end
      d = 4'b0000; step();
      checks++;
      if ({hi_out_valid, hi_y, hi_any, hi_multi, lo_y, lo_any} !== 8'b1_00_00_00_0) begin
         errors++; $display("FAIL prio_zero: got %b want 10000000", {hi_out_valid, hi_y, hi_any, hi_multi, lo_y, lo_any});
      end
      d = 4'b0110; step();
      checks++;
      if ({hi_y, lo_y, hi_multi} !== 5'b10_01_1) begin errors++; $display("FAIL prio_0110: got %b want 10011", {hi_y, lo_y, hi_multi}); end
      d = 4'b1000; step();
      checks++;
      if ({lo_y, lo_any, lo_multi} !== 4'b11_1_0) begin errors++; $display("FAIL prio_lo_1000: got %b want 1110", {lo_y, lo_any, lo_multi}); end
   endtask

   task automatic test_enable();
      en = 1'b0; d = 4'b1111; step();
      checks++;
      if ({hi_out_valid, hi_y, hi_any, hi_multi} !== 5'b1_00_00) begin
         errors++; $display("FAIL enable_gate: got %b want 10000", {hi_out_valid, hi_y, hi_any, hi_multi});
      end
      in_valid = 1'b0; step();
      checks++;
      if ({hi_out_valid, hi_cnt} !== {1'b0, 8'd9}) begin
         errors++; $display("FAIL enable_cnt: got valid=%b cnt=%0d want valid=0 cnt=9", hi_out_valid, hi_cnt);
      end
      en = 1'b1;
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; out_ready = 1'b1; d = 4'b0100; step();
      out_ready = 1'b0; d = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({hi_in_ready, hi_out_valid, hi_y} !== 4'b0_1_10) begin
            errors++; $display("FAIL stall_%0d: got %b want 0110", i, {hi_in_ready, hi_out_valid, hi_y});
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (hi_in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", hi_in_ready); end
      step();
      checks++;
      if ({hi_out_valid, hi_y, hi_cnt} !== {1'b1, 2'b11, 8'd10}) begin
         errors++; $display("FAIL release_load: got valid=%b y=%b cnt=%0d want valid=1 y=11 cnt=10", hi_out_valid, hi_y, hi_cnt);
      end
      in_valid = 1'b0; step();
   endtask

   task automatic test_saturation();
      rst = 1'b1; #2; rst = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1; d = 4'b0001;
      repeat (5) step();
      in_valid = 1'b0; step();
      checks++;
      if ({st_cnt, hi_cnt} !== {2'd3, 8'd5}) begin
         errors++; $display("FAIL saturate: got sat=%0d full=%0d want sat=3 full=5", st_cnt, hi_cnt);
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; out_ready = 1'b0; d = 4'b1100; step();
      checks++;
      if ({hi_out_valid, hi_y, hi_multi} !== 4'b1_11_1) begin errors++; $display("FAIL mid_full: got %b want 1111", {hi_out_valid, hi_y, hi_multi}); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({hi_out_valid, hi_y, hi_any, hi_multi, hi_cnt, st_cnt} !== {5'b0, 8'd0, 2'd0}) begin
         errors++; $display("FAIL async_reset: got valid=%b y=%b cnt=%0d sat=%0d want all zero", hi_out_valid, hi_y, hi_cnt, st_cnt);
      end
      in_valid = 1'b0; rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_priority();
      test_enable();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
